// File: rtl/secure_debug_key_vault.sv
// Multi-slot key store: debug access is only granted after every secret slot has been zeroized,
// and debug readback is limited to slots marked public.
module secure_debug_key_vault #(
  parameter int unsigned          KEY_W       = 128,
  parameter int unsigned          NUM_SLOTS   = 4,
  parameter int unsigned          SLOT_W      = $clog2(NUM_SLOTS),
  parameter logic [NUM_SLOTS-1:0] PUBLIC_MASK = {NUM_SLOTS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_wr_en,
  input  logic [SLOT_W-1:0]    key_wr_slot,
  input  logic [KEY_W-1:0]     key_wr_data,
  input  logic                 key_rd_en,
  input  logic [SLOT_W-1:0]    key_rd_slot,
  output logic [KEY_W-1:0]     key_out,
  output logic                 key_out_valid,
  output logic [NUM_SLOTS-1:0] slot_valid,
  input  logic                 debug_req,
  output logic                 debug_ack,
  input  logic                 debug_rd_en,
  input  logic [SLOT_W-1:0]    debug_rd_slot,
  output logic [KEY_W-1:0]     debug_rd_data,
  output logic                 debug_rd_valid,
  output logic                 debug_rd_err,
  output logic                 scrub_busy
);

  typedef enum logic [1:0] {StFunc, StScrub, StDebug} state_e;

  localparam logic [SLOT_W-1:0] LastIdx = SLOT_W'(NUM_SLOTS - 1);

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     scrub_idx_q, scrub_idx_d;
  logic [KEY_W-1:0]      slots_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  slot_valid_q;
  logic [KEY_W-1:0]      key_out_q, debug_rd_data_q;
  logic                  key_out_valid_q, debug_rd_valid_q, debug_rd_err_q;

  logic wr_fire, rd_fire, dbg_fire, dbg_ok, scrub_clr;

  // Guards non-power-of-two slot counts where the index can exceed the array.
  function automatic logic in_range(input logic [SLOT_W-1:0] s);
    return int'(s) < NUM_SLOTS;
  endfunction

  always_comb begin
    state_d     = state_q;
    scrub_idx_d = scrub_idx_q;
    unique case (state_q)
      StFunc: begin
        if (debug_req) begin
          state_d     = StScrub;
          scrub_idx_d = '0;
        end
      end
      StScrub: begin
        scrub_idx_d = scrub_idx_q + SLOT_W'(1);
        if (scrub_idx_q == LastIdx) begin
          state_d     = debug_req ? StDebug : StFunc;
          scrub_idx_d = '0;
        end
      end
      StDebug: begin
        if (!debug_req) state_d = StFunc;
      end
      default: state_d = StFunc;
    endcase
  end

  // A debug request in the same cycle as a functional access always wins.
  always_comb begin
    wr_fire   = (state_q == StFunc) && key_wr_en && !debug_req && in_range(key_wr_slot);
    rd_fire   = (state_q == StFunc) && key_rd_en && !debug_req && in_range(key_rd_slot) &&
                slot_valid_q[key_rd_slot];
    dbg_fire  = (state_q == StDebug) && debug_rd_en;
    dbg_ok    = in_range(debug_rd_slot) && PUBLIC_MASK[debug_rd_slot];
    scrub_clr = (state_q == StScrub) && !PUBLIC_MASK[scrub_idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFunc;
      scrub_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      scrub_idx_q <= scrub_idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) slots_q[i] <= '0;
      slot_valid_q     <= '0;
      key_out_q        <= '0;
      key_out_valid_q  <= 1'b0;
      debug_rd_data_q  <= '0;
      debug_rd_valid_q <= 1'b0;
      debug_rd_err_q   <= 1'b0;
    end else begin
      if (wr_fire) begin
        slots_q[key_wr_slot]      <= key_wr_data;
        slot_valid_q[key_wr_slot] <= 1'b1;
      end
      if (scrub_clr) begin
        slots_q[scrub_idx_q]      <= '0;
        slot_valid_q[scrub_idx_q] <= 1'b0;
      end
      key_out_q        <= rd_fire ? slots_q[key_rd_slot] : '0;
      key_out_valid_q  <= rd_fire;
      debug_rd_data_q  <= (dbg_fire && dbg_ok) ? slots_q[debug_rd_slot] : '0;
      debug_rd_valid_q <= dbg_fire;
      debug_rd_err_q   <= dbg_fire && !dbg_ok;
    end
  end

  assign key_out        = key_out_q;
  assign key_out_valid  = key_out_valid_q;
  assign slot_valid     = slot_valid_q;
  assign debug_rd_data  = debug_rd_data_q;
  assign debug_rd_valid = debug_rd_valid_q;
  assign debug_rd_err   = debug_rd_err_q;
  assign scrub_busy     = (state_q == StScrub);
  assign debug_ack      = (state_q == StDebug);

endmodule

// File: tb/tb_secure_debug_key_vault.sv
// Scoreboard bench for secure_debug_key_vault: a mode/countdown reference model queues expected
// responses; a negedge monitor pops and compares them against the DUT.
module tb_secure_debug_key_vault;

  localparam int KW = 128;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam logic [NS-1:0] PUB = 4'b0001;

  localparam int MFunc  = 0;
  localparam int MScrub = 1;
  localparam int MDebug = 2;

  typedef struct packed {
    int unsigned   tag;
    logic [KW-1:0] data;
    logic          err;
  } resp_t;

  logic          clk, rst;
  logic          key_wr_en, key_rd_en, debug_req, debug_rd_en;
  logic [SW-1:0] key_wr_slot, key_rd_slot, debug_rd_slot;
  logic [KW-1:0] key_wr_data, key_out, debug_rd_data;
  logic          key_out_valid, debug_ack, debug_rd_valid, debug_rd_err, scrub_busy;
  logic [NS-1:0] slot_valid;

  secure_debug_key_vault #(
    .KEY_W      (KW),
    .NUM_SLOTS  (NS),
    .SLOT_W     (SW),
    .PUBLIC_MASK(PUB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_wr_en     (key_wr_en),
    .key_wr_slot   (key_wr_slot),
    .key_wr_data   (key_wr_data),
    .key_rd_en     (key_rd_en),
    .key_rd_slot   (key_rd_slot),
    .key_out       (key_out),
    .key_out_valid (key_out_valid),
    .slot_valid    (slot_valid),
    .debug_req     (debug_req),
    .debug_ack     (debug_ack),
    .debug_rd_en   (debug_rd_en),
    .debug_rd_slot (debug_rd_slot),
    .debug_rd_data (debug_rd_data),
    .debug_rd_valid(debug_rd_valid),
    .debug_rd_err  (debug_rd_err),
    .scrub_busy    (scrub_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: operating mode, remaining scrub visits, key contents and provisioned flags.
  logic [KW-1:0] m_key [NS];
  logic [NS-1:0] m_val;
  int            m_mode;
  int            m_left;
  int unsigned   cyc = 0;
  resp_t         key_q[$];
  resp_t         dbg_q[$];

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_key[i] = '0;
    m_val  = '0;
    m_mode = MFunc;
    m_left = 0;
    key_q.delete();
    dbg_q.delete();
  endtask

  task automatic model_step();
    int    idx;
    logic  pub;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == MFunc && key_rd_en && !debug_req && int'(key_rd_slot) < NS &&
        m_val[key_rd_slot])
      key_q.push_back('{tag: cyc, data: m_key[key_rd_slot], err: 1'b0});
    if (m_mode == MDebug && debug_rd_en) begin
      pub = int'(debug_rd_slot) < NS && PUB[debug_rd_slot];
      dbg_q.push_back('{tag: cyc, data: pub ? m_key[debug_rd_slot] : '0, err: !pub});
    end
    case (m_mode)
      MFunc: begin
        if (debug_req) begin
          m_mode = MScrub;
          m_left = NS;
        end else if (key_wr_en && int'(key_wr_slot) < NS) begin
          m_key[key_wr_slot] = key_wr_data;
          m_val[key_wr_slot] = 1'b1;
        end
      end
      MScrub: begin
        idx = NS - m_left;
        if (!PUB[idx]) begin
          m_key[idx] = '0;
          m_val[idx] = 1'b0;
        end
        m_left--;
        if (m_left == 0) m_mode = debug_req ? MDebug : MFunc;
      end
      default: if (!debug_req) m_mode = MFunc;
    endcase
  endtask

  // Monitor: pops expected responses whose tag matches the current cycle.
  initial begin
    resp_t r;
    logic  exp_v;
    forever begin
      @(negedge clk);
      r     = '0;
      exp_v = key_q.size() > 0 && key_q[0].tag == cyc;
      if (exp_v) r = key_q.pop_front();
      chk("key_out_valid", KW'(key_out_valid), KW'(exp_v));
      chk("key_out", key_out, r.data);
      r     = '0;
      exp_v = dbg_q.size() > 0 && dbg_q[0].tag == cyc;
      if (exp_v) r = dbg_q.pop_front();
      chk("debug_rd_valid", KW'(debug_rd_valid), KW'(exp_v));
      chk("debug_rd_data", debug_rd_data, r.data);
      chk("debug_rd_err", KW'(debug_rd_err), KW'(r.err));
      chk("scrub_busy", KW'(scrub_busy), KW'(m_mode == MScrub));
      chk("debug_ack", KW'(debug_ack), KW'(m_mode == MDebug));
      chk("slot_valid", KW'(slot_valid), KW'(m_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    key_wr_en   = 1'b0;
    key_rd_en   = 1'b0;
    debug_rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int s, input logic [KW-1:0] d);
    key_wr_en   = 1'b1;
    key_wr_slot = SW'(s);
    key_wr_data = d;
    tick();
  endtask

  task automatic rd(input int s);
    key_rd_en   = 1'b1;
    key_rd_slot = SW'(s);
    tick();
  endtask

  task automatic drd(input int s);
    debug_rd_en   = 1'b1;
    debug_rd_slot = SW'(s);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_key_out"}, key_out, '0);
    chk({tag, "_key_out_valid"}, KW'(key_out_valid), '0);
    chk({tag, "_debug_rd_data"}, debug_rd_data, '0);
    chk({tag, "_debug_rd_valid"}, KW'(debug_rd_valid), '0);
    chk({tag, "_debug_rd_err"}, KW'(debug_rd_err), '0);
    chk({tag, "_scrub_busy"}, KW'(scrub_busy), '0);
    chk({tag, "_debug_ack"}, KW'(debug_ack), '0);
    chk({tag, "_slot_valid"}, KW'(slot_valid), '0);
  endtask

  // Asserts rst between clock edges and expects every output to clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    debug_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [KW-1:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [KW-1:0] k;
    rst = 1'b1;
    key_wr_en = 1'b0; key_rd_en = 1'b0; debug_req = 1'b0; debug_rd_en = 1'b0;
    key_wr_slot = '0; key_rd_slot = '0; debug_rd_slot = '0; key_wr_data = '0;
    model_reset();
    #2;
    check_all_zero("por");
    idle(2);
    rst = 1'b0;

    // Provisioning.
    k = 128'h0123456789ABCDEF0123456789ABCDEF;
    wr(2, k);
    rd(2);
    idle(1);

    // Full scrub into debug, public and secret readback.
    wr(0, {32{4'hA}});
    wr(1, {32{4'hB}});
    wr(2, {32{4'hC}});
    wr(3, {32{4'hD}});
    debug_req = 1'b1;
    idle(NS + 2);
    drd(0);
    drd(1);
    drd(2);
    drd(3);
    idle(1);

    // Debug exit: secret slot stays invalid until re-provisioned.
    debug_req = 1'b0;
    idle(1);
    rd(3);
    wr(3, {32{4'hE}});
    rd(3);
    rd(0);
    idle(1);

    // Abort mid-scrub.
    debug_req = 1'b1;
    idle(2);
    debug_req = 1'b0;
    idle(NS + 2);
    rd(0);

    // Write colliding with the debug request is dropped.
    wr(1, {32{4'h5}});
    key_wr_en = 1'b1; key_wr_slot = 2'd1; key_wr_data = {32{4'hF}};
    key_rd_en = 1'b1; key_rd_slot = 2'd0;
    debug_req = 1'b1;
    tick();
    idle(NS + 1);
    drd(1);
    drd(0);
    debug_req = 1'b0;
    idle(1);

    // Reset during SCRUB and during DEBUG.
    wr(0, rnd_key());
    wr(2, rnd_key());
    debug_req = 1'b1;
    idle(2);
    async_reset("rst_scrub");
    idle(1);
    wr(0, rnd_key());
    debug_req = 1'b1;
    idle(NS + 2);
    drd(0);
    async_reset("rst_debug");
    rd(0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) debug_req = ~debug_req;
      key_wr_en     = $urandom_range(2) == 0;
      key_wr_slot   = SW'($urandom);
      key_wr_data   = rnd_key();
      key_rd_en     = $urandom_range(1) == 0;
      key_rd_slot   = SW'($urandom);
      debug_rd_en   = $urandom_range(1) == 0;
      debug_rd_slot = SW'($urandom);
      if ($urandom_range(299) == 0) async_reset("rst_rand");
      else tick();
    end
    debug_req = 1'b0;
    idle(NS + 3);

    chk("key_q_drained", KW'(key_q.size()), '0);
    chk("dbg_q_drained", KW'(dbg_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
